// File: rtl/vga_sync.sv
// VGA timing generator: pixel/line counters advanced on each rising edge of dclk
// as sampled on clk; syncs and video_on are registered from next-state counters.
module vga_sync #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       dclk,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);

  // 11-bit bounds so a sync pulse ending exactly at 1024 cannot wrap
  localparam logic [10:0] H_VIS_L = 11'(H_VIS);
  localparam logic [10:0] HS_BEG  = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_L = 11'(V_VIS);
  localparam logic [10:0] VS_BEG  = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_VIS + V_FP + V_SYNC);

  logic       dclk_q;
  logic       tick;
  logic [9:0] hc_nxt;
  logic [9:0] vc_nxt;
  logic [10:0] hc_ext;
  logic [10:0] vc_ext;

  assign tick   = dclk & ~dclk_q;
  assign hc_ext = {1'b0, hc_nxt};
  assign vc_ext = {1'b0, vc_nxt};

  always_comb begin
    hc_nxt = hc + 10'd1;
    vc_nxt = vc;
    if (hc == H_MAX) begin
      hc_nxt = '0;
      vc_nxt = (vc == V_MAX) ? '0 : vc + 10'd1;
    end
  end

  // dclk_q resets high so a dclk already high at release is not a tick
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dclk_q      <= 1'b1;
      hc          <= H_MAX;
      vc          <= V_MAX;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      dclk_q      <= dclk;
      frame_start <= 1'b0;
      if (tick) begin
        hc          <= hc_nxt;
        vc          <= vc_nxt;
        hsync       <= ~((hc_ext >= HS_BEG) && (hc_ext < HS_END));
        vsync       <= ~((vc_ext >= VS_BEG) && (vc_ext < VS_END));
        video_on    <= (hc_ext < H_VIS_L) && (vc_ext < V_VIS_L);
        frame_start <= (hc_nxt == 10'd0) && (vc_nxt == 10'd0);
      end
    end
  end

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync with reduced timing so full frames stay short; expected
// outputs come from the tick count since reset mapped onto the raster.
module tb_vga_sync;

  localparam int H_VIS  = 20;
  localparam int H_FP   = 4;
  localparam int H_SYNC = 6;
  localparam int H_BP   = 5;
  localparam int V_VIS  = 12;
  localparam int V_FP   = 2;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 3;
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FT = HT * VT;

  logic       clk;
  logic       clr_n;
  logic       dclk;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;

  int checks = 0;
  int errors = 0;
  int n      = 0;   // pixel ticks since reset release
  int fs_exp = 0;
  int hs_low = 0;
  int vs_low = 0;
  int fs_cnt = 0;

  vga_sync #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .clr_n(clr_n), .dclk(dclk), .hc(hc), .vc(vc),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endfunction

  // Raster position is the tick count modulo the frame; zero ticks means the
  // last pixel of the last line, so the first tick lands on (0,0).
  function automatic int m_idx();
    return (n + FT - 1) % FT;
  endfunction
  function automatic int m_hc();
    return m_idx() % HT;
  endfunction
  function automatic int m_vc();
    return m_idx() / HT;
  endfunction

  task automatic check_all(string tag);
    int h, v;
    h = m_hc();
    v = m_vc();
    chk({tag, ".hc"}, 32'(hc), 32'(h));
    chk({tag, ".vc"}, 32'(vc), 32'(v));
    chk({tag, ".hsync"}, 32'(hsync),
        32'(!(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC)));
    chk({tag, ".vsync"}, 32'(vsync),
        32'(!(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC)));
    chk({tag, ".video_on"}, 32'(video_on), 32'(n > 0 && h < H_VIS && v < V_VIS));
    chk({tag, ".frame_start"}, 32'(frame_start), 32'(fs_exp));
  endtask

  task automatic pix_tick(input int hi, input int lo, input string tag);
    dclk = 1'b1;
    for (int i = 0; i < hi; i++) begin
      @(posedge clk);
      if (i == 0) begin
        n++;
        fs_exp = (m_idx() == 0) ? 1 : 0;
      end else begin
        fs_exp = 0;
      end
      #1;
      check_all(tag);
      if (i == 0) begin
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
      end
      if (frame_start) fs_cnt++;
    end
    dclk = 1'b0;
    for (int i = 0; i < lo; i++) begin
      @(posedge clk);
      fs_exp = 0;
      #1;
      check_all({tag, "_lo"});
    end
  endtask

  task automatic rnd_tick(input string tag);
    pix_tick(int'($urandom_range(3, 1)), int'($urandom_range(3, 1)), tag);
  endtask

  initial begin
    clr_n = 1'b0;
    dclk  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.dclk_q", 32'(dut.dclk_q), 32'd1);
    clr_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rel");

    // first tick goes to (0,0) with a single-cycle frame_start
    pix_tick(1, 2, "first");
    chk("first.fs_cnt", 32'(fs_cnt), 32'd1);

    // first line: sync width and wrap to line 1
    hs_low = 0;
    for (int i = 1; i < HT; i++) rnd_tick("line");
    chk("line.hsync_width", 32'(hs_low), 32'(H_SYNC));
    rnd_tick("wrap");
    chk("wrap.hc", 32'(hc), 32'd0);
    chk("wrap.vc", 32'(vc), 32'd1);

    // long dclk high phase: exactly one increment
    pix_tick(10, 2, "long_hi");
    chk("long_hi.hc", 32'(hc), 32'd1);

    // rest of the frame up to the second frame_start
    vs_low = 0;
    fs_cnt = 0;
    while (n < FT + 1) rnd_tick("frame");
    chk("frame.fs_cnt", 32'(fs_cnt), 32'd1);
    chk("frame.vsync_ticks", 32'(vs_low), 32'(V_SYNC * HT));
    chk("frame.origin_hc", 32'(hc), 32'd0);
    chk("frame.origin_vc", 32'(vc), 32'd0);

    // mid-frame asynchronous reset
    for (int i = 0; i < FT && !(m_hc() == 10 && m_vc() == 7); i++) rnd_tick("seek");
    chk("seek.hc", 32'(hc), 32'd10);
    chk("seek.vc", 32'(vc), 32'd7);
    @(posedge clk);
    #3;
    clr_n = 1'b0;
    n = 0;
    fs_exp = 0;
    #1;
    check_all("async_rst");

    // release with dclk already high: no tick until a fresh rising edge
    dclk = 1'b1;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      check_all("rel_hi");
    end
    dclk = 1'b0;
    @(posedge clk);
    #1;
    check_all("rel_lo");
    fs_cnt = 0;
    pix_tick(1, 1, "rel_tick");
    chk("rel_tick.hc", 32'(hc), 32'd0);
    chk("rel_tick.fs_cnt", 32'(fs_cnt), 32'd1);
    for (int i = 0; i < 5; i++) rnd_tick("tail");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 SHALL have parameter H_VIS, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VIS, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1, master clock; all state on its rising edge.
REQ-010 SHALL have port clr_n, input, 1, reset; asynchronous and active-low.
REQ-011 SHALL have port dclk, input, 1, pixel clock from the clock divider, treated as a level sampled on clk.
REQ-012 SHALL have port hc, output, 10, current pixel column.
REQ-013 SHALL have port vc, output, 10, current line.
REQ-014 SHALL have port hsync, output, 1, horizontal sync, active-low.
REQ-015 SHALL have port vsync, output, 1, vertical sync, active-low.
REQ-016 SHALL have port video_on, output, 1, high inside the visible region.
REQ-017 SHALL have port frame_start, output, 1, one-clk pulse at start of a frame.

Function
REQ-018 SHALL register dclk into dclk_q each clk; pixel tick = dclk high and dclk_q low in the same clk cycle.
REQ-019 SHALL hold hc, vc and all outputs unchanged on clk cycles without a pixel tick, except frame_start, which deasserts.
REQ-020 SHALL, on a pixel tick, increment hc; if hc = H_TOTAL-1 (H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP), set hc to 0 and advance vc.
REQ-021 SHALL advance vc by incrementing; if vc = V_TOTAL-1 (V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP), set vc to 0.
REQ-022 SHALL register hsync, vsync and video_on from the next-state counter values, so they match hc/vc in the same cycle with zero added latency.
REQ-023 SHALL drive hsync low iff H_VIS+H_FP <= hc < H_VIS+H_FP+H_SYNC (656..751 default).
REQ-024 SHALL drive vsync low iff V_VIS+V_FP <= vc < V_VIS+V_FP+V_SYNC (490..491 default).
REQ-025 SHALL drive video_on high iff hc < H_VIS and vc < V_VIS.
REQ-026 SHALL pulse frame_start high for exactly one clk cycle, namely the cycle in which hc and vc both become 0.
REQ-027 SHALL use unsigned 10-bit arithmetic; H_TOTAL and V_TOTAL SHALL each be <= 1024; counters never exceed TOTAL-1.
REQ-028 SHALL produce at most one tick per dclk high phase, however long dclk remains high.

Reset
REQ-029 SHALL, while clr_n low, force hc = H_TOTAL-1 (799), vc = V_TOTAL-1 (524), hsync = 1, vsync = 1, video_on = 0, frame_start = 0, dclk_q = 1.
REQ-030 SHALL ignore a dclk already high at reset release, because dclk_q = 1; the first tick requires a fresh dclk rising edge.
REQ-031 SHALL make the first tick after reset move to (0,0) with video_on = 1 and frame_start pulsed.
REQ-032 SHALL return immediately to REQ-029 values when reset is asserted mid-frame, with no completion of the current line.

Verification
REQ-033 Reset, then one dclk rising edge -> hc=0, vc=0, video_on=1, frame_start high for 1 clk only.
REQ-034 Free-run 800 ticks from (0,0) -> hsync low exactly at hc 656..751; wrap to hc=0, vc=1 on tick 800.
REQ-035 Run a full frame of 420000 ticks -> vsync low for lines 490..491 only; video_on low for hc>=640 or vc>=480; a second frame_start at tick 420000.
REQ-036 Hold dclk high for 10 clk cycles -> exactly one hc increment.
REQ-037 Assert clr_n low at hc=300, vc=200 -> hc=799, vc=524, hsync=1, vsync=1, video_on=0 asynchronously, before the next clk edge.
REQ-038 Release reset with dclk=1 -> no tick until dclk goes 0 then 1; hc stays 799.
